// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the datapath.
// The controller holds the master side; the datapath (or a bench) holds the slave side.
interface multi_cycle_ctrl_if;
  logic [5:0] op;
  logic       zero;
  logic [2:0] state;
  logic       PCWre;
  logic       IRWre;
  logic       RegWre;
  logic       mRD;
  logic       mWR;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic       RegDst;
  logic       DBDataSrc;
  logic       ExtSel;
  logic [2:0] ALUOp;
  logic [1:0] PCSrc;
  logic       halted;

  modport master (
    input  op, zero,
    output state, PCWre, IRWre, RegWre, mRD, mWR,
    output ALUSrcA, ALUSrcB, RegDst, DBDataSrc, ExtSel,
    output ALUOp, PCSrc, halted
  );

  modport slave (
    output op, zero,
    input  state, PCWre, IRWre, RegWre, mRD, mWR,
    input  ALUSrcA, ALUSrcB, RegDst, DBDataSrc, ExtSel,
    input  ALUOp, PCSrc, halted
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU controller: IF/ID/EXE/MEM/WB sequencing FSM with a sticky halt,
// producing datapath enables and selects from the registered state and the opcode.
module multi_cycle_ctrl (
  input  logic               CLK,
  input  logic               Reset,
  multi_cycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic   halted_reg;
  logic   halted_next;
  logic   last_cycle;
  logic   run;

  logic is_ralu;
  logic is_ialu;
  logic is_sw;
  logic is_lw;
  logic is_beq;
  logic is_bne;
  logic is_j;
  logic is_jr;
  logic is_halt;
  logic br_taken;

  always_comb begin
    is_ralu  = (bus.op[5:3] == 3'b000);
    is_ialu  = (bus.op[5:3] == 3'b010);
    is_sw    = (bus.op == 6'b110000);
    is_lw    = (bus.op == 6'b110001);
    is_beq   = (bus.op == 6'b110100);
    is_bne   = (bus.op == 6'b110101);
    is_j     = (bus.op == 6'b111000);
    is_jr    = (bus.op == 6'b111001);
    is_halt  = (bus.op == 6'b111111);
    br_taken = (is_beq & bus.zero) | (is_bne & ~bus.zero);
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_reg  <= S_IF;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      halted_reg <= halted_next;
    end
  end

  // last_cycle marks the state whose successor is IF; it is what advances the PC.
  always_comb begin
    state_next  = state_reg;
    halted_next = halted_reg;
    last_cycle  = 1'b0;
    case (state_reg)
      S_IF: state_next = S_ID;
      S_ID: begin
        if (halted_reg) begin
          state_next = S_ID;
        end else if (is_halt) begin
          state_next  = S_ID;
          halted_next = 1'b1;
        end else if (is_ralu || is_ialu) begin
          state_next = S_EXE_AL;
        end else if (is_beq || is_bne) begin
          state_next = S_EXE_BR;
        end else if (is_sw || is_lw) begin
          state_next = S_EXE_LS;
        end else begin
          state_next = S_IF;
          last_cycle = 1'b1;
        end
      end
      S_EXE_AL: state_next = S_WB_AL;
      S_WB_AL: begin
        state_next = S_IF;
        last_cycle = 1'b1;
      end
      S_EXE_BR: begin
        state_next = S_IF;
        last_cycle = 1'b1;
      end
      S_EXE_LS: state_next = S_MEM;
      S_MEM: begin
        if (is_lw) begin
          state_next = S_WB_LD;
        end else begin
          state_next = S_IF;
          last_cycle = 1'b1;
        end
      end
      S_WB_LD: begin
        state_next = S_IF;
        last_cycle = 1'b1;
      end
      default: state_next = S_IF;
    endcase
  end

  // Enables are suppressed combinationally while reset is held or the core is halted.
  always_comb begin
    run           = Reset & ~halted_reg;
    bus.state     = state_reg;
    bus.halted    = halted_reg;
    bus.PCWre     = run & last_cycle;
    bus.IRWre     = run & (state_reg == S_IF);
    bus.RegWre    = run & ((state_reg == S_WB_AL) | (state_reg == S_WB_LD));
    bus.mRD       = run & (state_reg == S_MEM) & is_lw;
    bus.mWR       = run & (state_reg == S_MEM) & is_sw;
    bus.DBDataSrc = (state_reg == S_WB_LD);
    bus.RegDst    = is_ralu;
    bus.ALUSrcB   = is_ialu | is_lw | is_sw;
    bus.ALUSrcA   = (bus.op == 6'b000110);
    bus.ExtSel    = ~(is_ialu & ~bus.op[2] & (bus.op[1] | bus.op[0]));

    bus.PCSrc = 2'b00;
    if (run) begin
      if (state_reg == S_EXE_BR && br_taken) begin
        bus.PCSrc = 2'b01;
      end else if (state_reg == S_ID && is_j) begin
        bus.PCSrc = 2'b10;
      end else if (state_reg == S_ID && is_jr) begin
        bus.PCSrc = 2'b11;
      end
    end

    bus.ALUOp = 3'b000;
    if (Reset) begin
      case (state_reg)
        S_EXE_AL: bus.ALUOp = bus.op[2:0];
        S_EXE_BR: bus.ALUOp = 3'b001;
        default:  bus.ALUOp = 3'b000;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: vector table, hand-written corner sequences, and
// random instruction streams checked against an instruction-level path model.
module tb_multi_cycle_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl dut (
    .CLK   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  localparam logic [2:0] IF_S = 3'b000, ID_S = 3'b001, EXE_LS_S = 3'b010, MEM_S = 3'b011;
  localparam logic [2:0] WB_LD_S = 3'b100, EXE_BR_S = 3'b101, EXE_AL_S = 3'b110, WB_AL_S = 3'b111;

  typedef enum int {K_RALU, K_IALU, K_SW, K_LW, K_BEQ, K_BNE, K_J, K_JR, K_HALT, K_NOP} kind_t;

  typedef struct packed {
    logic       PCWre;
    logic       IRWre;
    logic       RegWre;
    logic       mRD;
    logic       mWR;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic       RegDst;
    logic       DBDataSrc;
    logic       ExtSel;
    logic [2:0] ALUOp;
    logic [1:0] PCSrc;
  } outs_t;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    int          len;
    logic [14:0] states;
    logic [1:0]  pcsrc_fin;
  } vec_t;

  int total = 0;
  int bad = 0;
  vec_t tbl[14];
  logic [5:0] valid_ops[10];
  logic [2:0] path_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic kind_t kind_of(input logic [5:0] op);
    int v;
    v = int'(op);
    if (v <= 7) return K_RALU;
    if (v >= 16 && v <= 23) return K_IALU;
    case (v)
      48: return K_SW;
      49: return K_LW;
      52: return K_BEQ;
      53: return K_BNE;
      56: return K_J;
      57: return K_JR;
      63: return K_HALT;
      default: return K_NOP;
    endcase
  endfunction

  function automatic void build_path(input kind_t k);
    case (k)
      K_RALU, K_IALU: path_q = {IF_S, ID_S, EXE_AL_S, WB_AL_S};
      K_LW:           path_q = {IF_S, ID_S, EXE_LS_S, MEM_S, WB_LD_S};
      K_SW:           path_q = {IF_S, ID_S, EXE_LS_S, MEM_S};
      K_BEQ, K_BNE:   path_q = {IF_S, ID_S, EXE_BR_S};
      default:        path_q = {IF_S, ID_S};
    endcase
  endfunction

  // Expected outputs for one cycle of an instruction, from its phase and position.
  function automatic outs_t model_outs(input logic [2:0] st, input logic [5:0] op, input logic z,
                                       input bit last, input bit hlt, input bit rst_n);
    outs_t o;
    kind_t k;
    k = kind_of(op);
    o = '0;
    o.RegDst    = (k == K_RALU);
    o.ALUSrcB   = (k == K_IALU) || (k == K_LW) || (k == K_SW);
    o.ALUSrcA   = (op == 6'd6);
    o.ExtSel    = !(op >= 6'd17 && op <= 6'd19);
    o.DBDataSrc = (st == WB_LD_S);
    if (rst_n && !hlt) begin
      o.IRWre  = (st == IF_S);
      o.PCWre  = last;
      o.RegWre = (st == WB_AL_S) || (st == WB_LD_S);
      o.mRD    = (st == MEM_S) && (k == K_LW);
      o.mWR    = (st == MEM_S) && (k == K_SW);
      if (st == EXE_BR_S && ((k == K_BEQ && z) || (k == K_BNE && !z))) o.PCSrc = 2'd1;
      if (st == ID_S && k == K_J)  o.PCSrc = 2'd2;
      if (st == ID_S && k == K_JR) o.PCSrc = 2'd3;
    end
    if (rst_n) begin
      if (st == EXE_AL_S) o.ALUOp = op % 8;
      if (st == EXE_BR_S) o.ALUOp = 3'd1;
    end
    return o;
  endfunction

  function automatic outs_t cur_outs();
    outs_t o;
    o.PCWre     = bus.PCWre;
    o.IRWre     = bus.IRWre;
    o.RegWre    = bus.RegWre;
    o.mRD       = bus.mRD;
    o.mWR       = bus.mWR;
    o.ALUSrcA   = bus.ALUSrcA;
    o.ALUSrcB   = bus.ALUSrcB;
    o.RegDst    = bus.RegDst;
    o.DBDataSrc = bus.DBDataSrc;
    o.ExtSel    = bus.ExtSel;
    o.ALUOp     = bus.ALUOp;
    o.PCSrc     = bus.PCSrc;
    return o;
  endfunction

  task automatic check_cycle(input string tag, input logic [2:0] st, input outs_t exp, input logic hlt);
    chk({tag, " state"}, 32'(bus.state), 32'(st));
    chk({tag, " halted"}, 32'(bus.halted), 32'(hlt));
    chk({tag, " outs"}, 32'(cur_outs()), 32'(exp));
  endtask

  // Runs one instruction from IF; abort_at >= 0 pulls reset during that cycle.
  task automatic run_instr(input int idx, input logic [5:0] op, input logic z, input int abort_at);
    int n;
    build_path(kind_of(op));
    n = path_q.size();
    bus.op = op;
    bus.zero = z;
    #1;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        check_cycle("abort", path_q[i], model_outs(path_q[i], op, z, 1'b0, 1'b0, 1'b0), 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_cycle("after abort", IF_S, model_outs(IF_S, op, z, 1'b0, 1'b0, 1'b1), 1'b0);
        $display("instr %0d op=%b zero=%0d aborted in cycle %0d", idx, op, z, i);
        return;
      end
      check_cycle("run", path_q[i], model_outs(path_q[i], op, z, i == n - 1, 1'b0, 1'b1), 1'b0);
      @(posedge clk);
      #1;
    end
    $display("instr %0d op=%b zero=%0d cycles=%0d", idx, op, z, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{6'b000000, 1'b0, 4, 15'b000_111_110_001_000, 2'b00};
    tbl[1]  = '{6'b000110, 1'b1, 4, 15'b000_111_110_001_000, 2'b00};
    tbl[2]  = '{6'b010000, 1'b0, 4, 15'b000_111_110_001_000, 2'b00};
    tbl[3]  = '{6'b010001, 1'b1, 4, 15'b000_111_110_001_000, 2'b00};
    tbl[4]  = '{6'b110001, 1'b0, 5, 15'b100_011_010_001_000, 2'b00};
    tbl[5]  = '{6'b110000, 1'b0, 4, 15'b000_011_010_001_000, 2'b00};
    tbl[6]  = '{6'b110100, 1'b1, 3, 15'b000_000_101_001_000, 2'b01};
    tbl[7]  = '{6'b110100, 1'b0, 3, 15'b000_000_101_001_000, 2'b00};
    tbl[8]  = '{6'b110101, 1'b0, 3, 15'b000_000_101_001_000, 2'b01};
    tbl[9]  = '{6'b110101, 1'b1, 3, 15'b000_000_101_001_000, 2'b00};
    tbl[10] = '{6'b111000, 1'b0, 2, 15'b000_000_000_001_000, 2'b10};
    tbl[11] = '{6'b111001, 1'b0, 2, 15'b000_000_000_001_000, 2'b11};
    tbl[12] = '{6'b001000, 1'b0, 2, 15'b000_000_000_001_000, 2'b00};
    tbl[13] = '{6'b111110, 1'b1, 2, 15'b000_000_000_001_000, 2'b00};
    valid_ops = '{6'b000000, 6'b000110, 6'b010011, 6'b010101, 6'b110000,
                  6'b110001, 6'b110100, 6'b110101, 6'b111000, 6'b111001};

    // Held reset: enables and ALUOp/PCSrc forced low even with an ALU op present.
    reset = 1'b0;
    bus.op = 6'b000110;
    bus.zero = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cycle("reset", IF_S, model_outs(IF_S, 6'b000110, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
    chk("reset IRWre", 32'(bus.IRWre), 32'd0);

    // add after release
    reset = 1'b1;
    bus.op = 6'b000000;
    bus.zero = 1'b0;
    #1;
    chk("add c1 state", 32'(bus.state), 32'd0);
    chk("add c1 IRWre", 32'(bus.IRWre), 32'd1);
    @(posedge clk); #1;
    chk("add c2 state", 32'(bus.state), 32'd1);
    chk("add c2 PCWre", 32'(bus.PCWre), 32'd0);
    @(posedge clk); #1;
    chk("add c3 state", 32'(bus.state), 32'd6);
    @(posedge clk); #1;
    chk("add c4 state", 32'(bus.state), 32'd7);
    chk("add c4 RegWre", 32'(bus.RegWre), 32'd1);
    chk("add c4 PCWre", 32'(bus.PCWre), 32'd1);
    chk("add c4 RegDst", 32'(bus.RegDst), 32'd1);
    @(posedge clk); #1;
    chk("add c5 state", 32'(bus.state), 32'd0);
    $display("instr add hand sequence done");

    for (int v = 0; v < 14; v++) begin
      bus.op = tbl[v].op;
      bus.zero = tbl[v].z;
      #1;
      for (int i = 0; i < tbl[v].len; i++) begin
        chk("tbl state", 32'(bus.state), 32'(tbl[v].states[3*i +: 3]));
        if (i == tbl[v].len - 1) begin
          chk("tbl final PCWre", 32'(bus.PCWre), 32'd1);
          chk("tbl final PCSrc", 32'(bus.PCSrc), 32'(tbl[v].pcsrc_fin));
        end else begin
          chk("tbl early PCWre", 32'(bus.PCWre), 32'd0);
        end
        @(posedge clk);
        #1;
      end
      chk("tbl back to IF", 32'(bus.state), 32'd0);
      $display("vector %0d op=%b zero=%0d len=%0d", v, tbl[v].op, tbl[v].z, tbl[v].len);
    end

    // halt: sticky, holds ID with no enables until reset
    bus.op = 6'b111111;
    bus.zero = 1'b0;
    #1;
    check_cycle("halt IF", IF_S, model_outs(IF_S, 6'b111111, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
    @(posedge clk); #1;
    check_cycle("halt ID", ID_S, model_outs(ID_S, 6'b111111, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check_cycle("halted", ID_S, model_outs(ID_S, 6'b111111, 1'b0, 1'b0, 1'b1, 1'b1), 1'b1);
    end
    reset = 1'b0;
    #1;
    chk("halt reset PCWre", 32'(bus.PCWre), 32'd0);
    @(posedge clk); #1;
    chk("halt cleared state", 32'(bus.state), 32'd0);
    chk("halt cleared flag", 32'(bus.halted), 32'd0);
    reset = 1'b1;
    #1;
    $display("instr halt sequence done");

    // sw interrupted by reset while in MEM
    bus.op = 6'b110000;
    bus.zero = 1'b0;
    #1;
    chk("sw IF", 32'(bus.state), 32'd0);
    @(posedge clk); #1;
    chk("sw ID", 32'(bus.state), 32'd1);
    @(posedge clk); #1;
    chk("sw EXE", 32'(bus.state), 32'd2);
    chk("sw EXE mWR", 32'(bus.mWR), 32'd0);
    @(posedge clk); #1;
    chk("sw MEM", 32'(bus.state), 32'd3);
    reset = 1'b0;
    #1;
    chk("sw MEM rst mWR", 32'(bus.mWR), 32'd0);
    chk("sw MEM rst PCWre", 32'(bus.PCWre), 32'd0);
    @(posedge clk); #1;
    chk("sw post rst state", 32'(bus.state), 32'd0);
    chk("sw post rst mWR", 32'(bus.mWR), 32'd0);
    chk("sw post rst PCWre", 32'(bus.PCWre), 32'd0);
    reset = 1'b1;
    #1;
    chk("sw release state", 32'(bus.state), 32'd0);
    chk("sw release PCWre", 32'(bus.PCWre), 32'd0);
    chk("sw release IRWre", 32'(bus.IRWre), 32'd1);
    $display("instr sw reset-in-MEM sequence done");

    for (int n = 0; n < 60; n++) begin
      logic [5:0] rop;
      logic       rz;
      int         ab;
      if ($urandom_range(1, 0) == 1) rop = valid_ops[$urandom_range(9, 0)];
      else rop = 6'($urandom);
      if (rop == 6'b111111) rop = 6'b111110;
      rz = 1'($urandom);
      ab = ($urandom_range(7, 0) == 0) ? int'($urandom_range(4, 0)) : -1;
      run_instr(n, rop, rz, ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
